// File: rtl/fifo_pkt_pkg.sv
// rtl/fifo_pkt_pkg.sv - shared types and constants for the FIFO packet framer
package fifo_pkt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAD  = 2'd2
    } state_e;

    localparam int TUSER_HDR = 0;
    localparam int TUSER_PAD = 1;
    localparam int PKT_CNT_W = 16;

endpackage

// File: rtl/fifo_pkt_out_reg.sv
// rtl/fifo_pkt_out_reg.sv - single-stage valid/ready output register with load/hold/clear
module fifo_pkt_out_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  last_i,
    input  logic [1:0]            user_i,
    input  logic                  ready_i,
    output logic                  valid_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  last_o,
    output logic [1:0]            user_o,
    output logic                  load_ok_o
);

    logic                  valid_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  last_q;
    logic [1:0]            user_q;

    // The register may take a new word when it is empty or its word leaves this cycle.
    assign load_ok_o = ~valid_q | ready_i;

    assign valid_o = valid_q;
    assign data_o  = data_q;
    assign last_o  = last_q;
    assign user_o  = user_q;

    // Load a new word, drop valid once the held word is accepted, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            last_q  <= 1'b0;
            user_q  <= 2'b00;
        end else if (load_i) begin
            valid_q <= 1'b1;
            data_q  <= data_i;
            last_q  <= last_i;
            user_q  <= user_i;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

endmodule

// File: rtl/fifo_pkt_framer.sv
// rtl/fifo_pkt_framer.sv - frames FWFT FIFO words into header + fixed-length packets
module fifo_pkt_framer
    import fifo_pkt_pkg::*;
#(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    PKT_LEN    = 8,
    parameter int                    SEQ_WIDTH  = 8,
    parameter int                    TIMEOUT    = 16,
    parameter logic [DATA_WIDTH-1:0] PAD_VALUE  = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    input  logic                  m_tready,
    output logic                  m_tlast,
    output logic [1:0]            m_tuser,
    output logic [PKT_CNT_W-1:0]  pkt_cnt,
    output logic                  busy
);

    localparam int WC_W = $clog2(PKT_LEN + 1);
    localparam int IC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [WC_W-1:0] LAST_IDX = WC_W'(PKT_LEN - 1);
    localparam logic [IC_W-1:0] TO_IDX   = IC_W'(TIMEOUT - 1);

    state_e                 state_q, state_d;
    logic [SEQ_WIDTH-1:0]   seq_q, seq_d;
    logic [WC_W-1:0]        wc_q, wc_d;
    logic [IC_W-1:0]        ic_q, ic_d;
    logic [PKT_CNT_W-1:0]   pc_q, pc_d;

    logic                   load;
    logic [DATA_WIDTH-1:0]  ld_data;
    logic                   ld_last;
    logic [1:0]             ld_user;
    logic                   load_ok;
    logic                   last_word;

    assign last_word = (wc_q == LAST_IDX);
    assign pkt_cnt   = pc_q;
    assign busy      = (state_q != IDLE);

    // State and counter registers; reset abandons any partial packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            seq_q   <= '0;
            wc_q    <= '0;
            ic_q    <= '0;
            pc_q    <= '0;
        end else begin
            state_q <= state_d;
            seq_q   <= seq_d;
            wc_q    <= wc_d;
            ic_q    <= ic_d;
            pc_q    <= pc_d;
        end
    end

    // Next-state, counters, header/data/pad mux and pop strobe.
    always_comb begin
        state_d    = state_q;
        seq_d      = seq_q;
        wc_d       = wc_q;
        ic_d       = ic_q;
        pc_d       = pc_q;
        load       = 1'b0;
        ld_data    = '0;
        ld_last    = 1'b0;
        ld_user    = 2'b00;
        fifo_rd_en = 1'b0;
        case (state_q)
            IDLE: begin
                // Header is synthesised from seq; the FIFO is not popped for it.
                if (en && !fifo_empty && load_ok) begin
                    load               = 1'b1;
                    ld_data            = DATA_WIDTH'(seq_q);
                    ld_user[TUSER_HDR] = 1'b1;
                    wc_d               = '0;
                    ic_d               = '0;
                    state_d            = DATA;
                end
            end
            DATA: begin
                if (!fifo_empty) begin
                    // A non-empty FIFO stalled by backpressure does not age the timeout.
                    if (load_ok) begin
                        fifo_rd_en = ~rst;
                        load       = 1'b1;
                        ld_data    = fifo_dout;
                        ld_last    = last_word;
                        wc_d       = wc_q + 1'b1;
                        ic_d       = '0;
                        if (last_word) begin
                            seq_d   = seq_q + 1'b1;
                            pc_d    = pc_q + 1'b1;
                            state_d = IDLE;
                        end
                    end
                end else begin
                    ic_d = ic_q + 1'b1;
                    if ((TIMEOUT != 0) && (ic_q == TO_IDX)) begin
                        state_d = PAD;
                    end
                end
            end
            PAD: begin
                // Fill the rest of the packet; FIFO words wait for the next packet.
                if (load_ok) begin
                    load               = 1'b1;
                    ld_data            = PAD_VALUE;
                    ld_user[TUSER_PAD] = 1'b1;
                    ld_last            = last_word;
                    wc_d               = wc_q + 1'b1;
                    if (last_word) begin
                        seq_d   = seq_q + 1'b1;
                        pc_d    = pc_q + 1'b1;
                        state_d = IDLE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    fifo_pkt_out_reg #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_out_reg (
        .clk       (clk),
        .rst       (rst),
        .load_i    (load),
        .data_i    (ld_data),
        .last_i    (ld_last),
        .user_i    (ld_user),
        .ready_i   (m_tready),
        .valid_o   (m_tvalid),
        .data_o    (m_tdata),
        .last_o    (m_tlast),
        .user_o    (m_tuser),
        .load_ok_o (load_ok)
    );

endmodule

// File: doc/fifo_pkt_framer.md
Name: fifo_pkt_framer

Overview:
- Downstream consumer of the dual-width sync FIFO, operated in FWFT mode with 8-bit dout.
- Pops FIFO words and frames them into fixed-length packets on a valid/ready stream.
- Each packet is one header word (sequence number) followed by PKT_LEN data words; tlast marks the final word.
- If the FIFO runs dry mid-packet for TIMEOUT cycles, the packet is completed with pad words.

Parameters:
- DATA_WIDTH, 8: FIFO dout and stream width; equals FIFO DOUT_WIDTH.
- PKT_LEN, 8: data words per packet, excluding the header; must be ≥1.
- SEQ_WIDTH, 8: sequence counter width; must be ≤ DATA_WIDTH.
- TIMEOUT, 16: consecutive empty cycles in DATA before padding starts; 0 disables padding (stall forever).
- PAD_VALUE, 0: data value of pad words.

Ports:
- clk, input, 1: sole clock.
- rst, input, 1: synchronous, active-high reset.
- en, input, 1: permits starting new packets.
- fifo_dout, input, DATA_WIDTH: FWFT head word; valid whenever ~fifo_empty.
- fifo_empty, input, 1: FIFO empty flag.
- fifo_rd_en, output, 1: pop strobe; head word is consumed on the same edge.
- m_tdata, output, DATA_WIDTH: stream data.
- m_tvalid, output, 1: stream valid.
- m_tready, input, 1: stream ready.
- m_tlast, output, 1: last word of packet.
- m_tuser, output, 2: bit0 = header word, bit1 = pad word.
- pkt_cnt, output, 16: count of completed packets; wraps.
- busy, output, 1: state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high. On reset:
  - all outputs 0, state IDLE.
  - seq, word_cnt, idle_cnt, pkt_cnt all 0.
- Output register rule: a single output register. load_ok = ~m_tvalid | m_tready.
  - m_tvalid is set on a load.
  - m_tvalid is cleared when m_tready=1 and there is no load.
  - m_tdata, m_tlast and m_tuser hold stable while m_tvalid & ~m_tready.
- fifo_rd_en = (state==DATA) & ~fifo_empty & load_ok. It is combinational and never asserted when fifo_empty.
- IDLE:
  - Transition condition: en & ~fifo_empty & load_ok.
  - Action: load header (m_tdata = zero-extended seq, m_tuser=01, m_tlast=0); clear word_cnt and idle_cnt; go to DATA.
  - The header does not pop the FIFO.
- DATA, on a pop:
  - Load fifo_dout with m_tuser=00 and m_tlast = (word_cnt==PKT_LEN-1).
  - word_cnt+1, idle_cnt cleared.
  - On the last word: seq+1 (wraps 2^SEQ_WIDTH-1 → 0), pkt_cnt+1, go to IDLE.
- DATA, when fifo_empty:
  - idle_cnt+1.
  - If TIMEOUT!=0 and idle_cnt==TIMEOUT-1: go to PAD.
  - idle_cnt does not advance while stalled by ~load_ok with FIFO non-empty.
- PAD:
  - On each load_ok: load PAD_VALUE with m_tuser=10 and m_tlast at the last word; no pop.
  - FIFO data arriving during PAD is ignored until the next packet.
  - On the last word: seq+1, pkt_cnt+1, go to IDLE.
- en deassert:
  - Mid-packet: the current packet completes normally.
  - In IDLE: no new packet starts; fifo_rd_en stays 0.
- Latency:
  - Header appears on m_tdata/m_tvalid one clk after IDLE sees ~fifo_empty.
  - First data word appears the cycle after the header.
  - Sustained throughput is 1 word/clk with m_tready=1; IDLE→header costs no bubble.
  - Back-to-back packets: header of packet N+1 directly follows tlast of packet N when the FIFO is non-empty.
- Reset mid-packet:
  - The partial packet is abandoned (no tlast emitted); m_tvalid=0 after the edge.
  - FIFO contents are untouched.
  - The next header carries seq 0.

Decomposition:
- Package fifo_pkt_pkg:
  - state enum {IDLE, DATA, PAD}.
  - TUSER_HDR=0, TUSER_PAD=1 bit indices.
  - PKT_CNT_W=16.
- One sub-module, fifo_pkt_out_reg: the valid/ready output register with load/hold/clear logic, exporting load_ok.
- FSM, counters and header mux stay in fifo_pkt_framer.

Test Plan:
- Nominal framing: PKT_LEN=4, m_tready=1, FIFO holds 0x01..0x08.
  - Stream is 0x00(hdr), 01, 02, 03, 04(tlast), then 0x01(hdr), 05..08(tlast, 08).
  - Ends with pkt_cnt=2, busy=0.
- Backpressure: same data, m_tready toggling 1,0,0,1,…
  - Identical word sequence; no drop or duplicate.
  - m_tdata stable whenever valid&~ready.
  - fifo_rd_en never 1 while m_tvalid&~m_tready.
- Timeout pad: PKT_LEN=4, TIMEOUT=16, push 0x11, 0x22 only.
  - Stream: hdr 0x00, 11, 22.
  - Exactly 16 empty cycles, then 00 (tuser=10), 00 (tuser=10, tlast).
  - A word pushed during PAD appears in the next packet after hdr 0x01.
- en control: deassert en after the 2nd data word with FIFO full.
  - Packet completes with tlast; then busy=0 and fifo_rd_en=0 for 20 cycles.
  - Re-assert en → hdr 0x01.
- Reset mid-packet: assert rst for 1 clk after 2 data words.
  - m_tvalid=0 next cycle, pkt_cnt=0.
  - Following packet header = 0x00.
- Sequence wrap: SEQ_WIDTH=8, PKT_LEN=1, stream 257 packets.
  - Header of packet 256 = 0x00; pkt_cnt=257.
